dummy_arbiter: RTL and testbench
================================

Name: dummy_arbiter

Overview:
- Shares one dummy coprocessor instance among NUM_REQ requesters (e.g. several cores or accelerator front-ends).
- Arbitrates issue requests round-robin and drives the coprocessor tag with the winning requester index.
- Returns each result to its originator by decoding the returned tag.
- Bounds in-flight operations per requester with saturating outstanding counters.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 32, operand/result width.
- MAX_OUTSTANDING, 8, maximum in-flight operations per requester (>=1).
- IdW (localparam), $clog2(NUM_REQ), requester index / coprocessor tag width.
- CntW (localparam), $clog2(MAX_OUTSTANDING+1), outstanding counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  synchronous flush; clears all state
- req_valid_i  in  NUM_REQ  issue valid per requester
- req_ready_o  out  NUM_REQ  issue ready per requester
- req_ctl_i  in  NUM_REQ x dummy_pkg::coproc_ctl_t  per-requester mode control
- req_rs1_i  in  NUM_REQ*DATA_WIDTH  first operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_rs2_i  in  NUM_REQ*DATA_WIDTH  second operands, same packing as req_rs1_i
- rsp_valid_o  out  NUM_REQ  result valid per requester
- rsp_ready_i  in  NUM_REQ  result ready per requester
- rsp_rd_o  out  DATA_WIDTH  result, shared by all requesters; qualified by rsp_valid_o
- cp_flush_o  out  1  flush to coprocessor; equals flush_i
- cp_valid_o  out  1  coprocessor input valid
- cp_ready_i  in  1  coprocessor input ready
- cp_ctl_o  out  coproc_ctl_t  mode control to coprocessor
- cp_tag_o  out  IdW  tag to coprocessor = granted requester index
- cp_rs1_o  out  DATA_WIDTH  first operand to coprocessor
- cp_rs2_o  out  DATA_WIDTH  second operand to coprocessor
- cp_valid_i  in  1  coprocessor result valid
- cp_ready_o  out  1  coprocessor result ready
- cp_tag_i  in  IdW  returned tag
- cp_rd_i  in  DATA_WIDTH  returned result
- busy_o  out  1  any outstanding counter nonzero
- err_o  out  1  registered one-cycle error pulse

Behaviour:
- Reset: rst_i=1 sampled at clk_i edge clears rr_ptr, lock flag, lock index, outstanding counters and err_o to 0.
  - Outputs while state is reset: busy_o=0, err_o=0, cp_valid_o=0 unless some req_valid_i=1.
- flush_i has the same effect as reset on internal state; cp_flush_o=flush_i combinationally.
  - In a flush cycle, all handshakes are ignored for counter update.
- Eligibility: eligible[i] = req_valid_i[i] && cnt[i] < MAX_OUTSTANDING.
- Grant (combinational):
  - lock=1: grant is the lock index, regardless of eligibility.
  - lock=0: grant is the first eligible index searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - No eligible requester and lock=0: cp_valid_o=0.
- Issue outputs:
  - cp_valid_o = req_valid_i[grant] (with the grant as above).
  - cp_ctl_o, cp_tag_o, cp_rs1_o, cp_rs2_o are the granted requester's fields; tag = grant.
  - req_ready_o[i] = cp_ready_i && (i==grant) && cp_valid_o; all other ready bits are 0.
- Lock (AXI-style stability):
  - Set, with lock index = grant, if cp_valid_o && !cp_ready_i.
  - Cleared on the issue handshake (cp_valid_o && cp_ready_i).
  - Requesters must hold valid and data stable while not accepted.
- rr_ptr: on issue handshake, rr_ptr <= (grant+1) mod NUM_REQ; otherwise unchanged.
- Response routing (combinational, zero latency):
  - tag_ok = cp_tag_i < NUM_REQ.
  - rsp_valid_o[i] = cp_valid_i && tag_ok && cp_tag_i==i.
  - rsp_rd_o = cp_rd_i.
  - cp_ready_o = tag_ok ? rsp_ready_i[cp_tag_i] : 1; an invalid-tag result is dropped.
- Counters:
  - cnt[i] +1 on issue handshake with grant==i.
  - cnt[i] -1 on response handshake with cp_tag_i==i.
  - Both in the same cycle (zero-latency comb-mode result) leaves cnt[i] unchanged.
  - Counter never exceeds MAX_OUTSTANDING (enforced by eligibility).
  - Decrement at 0 saturates at 0 and raises err_o.
- err_o <= 1 for one cycle after either: a response handshake with !tag_ok, or a decrement of a zero counter. Otherwise 0.
- busy_o = OR over i of (cnt[i]!=0), combinational from registers.
- Reset or flush while locked or with outstanding work: all state is cleared next cycle; in-flight coprocessor results are discarded because the coprocessor is flushed via cp_flush_o.

Test Plan:
- Reset, then all 4 requesters valid, cp_ready_i=1 constant, coprocessor in comb mode -> cp_tag_o sequence 0,1,2,3,0; each req_ready_o pulses once per 4 cycles; busy_o stays 0.
- Requester 2 valid, cp_ready_i=0 for 3 cycles; requester 0 raises valid in cycle 1 -> cp_tag_o stays 2 and cp_rs1_o stable for 3 cycles; after the handshake, requester 0 is granted next and rr_ptr=3.
- MAX_OUTSTANDING=2, requester 1 issues 3 ops, no responses -> third op blocked (req_ready_o[1]=0), cnt[1]=2, busy_o=1. Response with tag 1 -> third op issues the following cycle.
- Result with cp_tag_i=3, rsp_ready_i[3]=0 -> rsp_valid_o=4'b1000, cp_ready_o=0. Raise rsp_ready_i[3] -> handshake, cnt[3] decrements.
- Response with tag 0 while cnt[0]=0 -> cnt[0] stays 0; err_o=1 for exactly one cycle.
- Lock active with cnt={1,2,0,1}; assert flush_i for one cycle -> cp_flush_o=1 that cycle; next cycle all counters 0, busy_o=0, lock=0, rr_ptr=0.

Source files
------------

// File: rtl/dummy_arbiter.sv
// Round-robin issue arbiter in front of a single shared dummy coprocessor.
// Routes tagged results back to their originators and tracks per-requester in-flight work.
package dummy_pkg;
    typedef struct packed {
        logic [1:0] op;
        logic       comb_mode;
    } coproc_ctl_t;
endpackage

module dummy_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    flush_i,
    input  logic [NUM_REQ-1:0]                      req_valid_i,
    output logic [NUM_REQ-1:0]                      req_ready_o,
    input  dummy_pkg::coproc_ctl_t [NUM_REQ-1:0]    req_ctl_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]           req_rs1_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]           req_rs2_i,
    output logic [NUM_REQ-1:0]                      rsp_valid_o,
    input  logic [NUM_REQ-1:0]                      rsp_ready_i,
    output logic [DATA_WIDTH-1:0]                   rsp_rd_o,
    output logic                                    cp_flush_o,
    output logic                                    cp_valid_o,
    input  logic                                    cp_ready_i,
    output dummy_pkg::coproc_ctl_t                  cp_ctl_o,
    output logic [$clog2(NUM_REQ)-1:0]              cp_tag_o,
    output logic [DATA_WIDTH-1:0]                   cp_rs1_o,
    output logic [DATA_WIDTH-1:0]                   cp_rs2_o,
    input  logic                                    cp_valid_i,
    output logic                                    cp_ready_o,
    input  logic [$clog2(NUM_REQ)-1:0]              cp_tag_i,
    input  logic [DATA_WIDTH-1:0]                   cp_rd_i,
    output logic                                    busy_o,
    output logic                                    err_o
);
    localparam int IdW  = $clog2(NUM_REQ);
    localparam int CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam int NPad = 1 << IdW;

    logic [IdW-1:0]  rr_ptr_r;
    logic [IdW-1:0]  lock_idx_r;
    logic            lock_r;
    logic            err_r;
    logic [CntW-1:0] cnt_r      [NUM_REQ];
    logic [CntW-1:0] cnt_next_s [NUM_REQ];

    logic [IdW-1:0]  grant_s;
    logic [NPad-1:0] eligible_s;
    logic [NPad-1:0] req_valid_pad_s;
    logic [NPad-1:0] rsp_ready_pad_s;
    logic            any_elig_s;
    logic            issue_hs_s;
    logic            rsp_hs_s;
    logic            tag_ok_s;
    logic            err_next_s;
    logic [NUM_REQ-1:0] inc_s;
    logic [NUM_REQ-1:0] dec_s;

    // Index increment that wraps at NUM_REQ (which need not be a power of two).
    function automatic logic [IdW-1:0] wrap_inc(input logic [IdW-1:0] idx);
        if (32'(idx) == NUM_REQ - 1) begin
            return {IdW{1'b0}};
        end else begin
            return idx + IdW'(1);
        end
    endfunction

    // Eligibility and round-robin search; a held lock overrides the search result.
    always_comb begin : grant_search
        logic [IdW-1:0] idx_v;
        eligible_s      = {NPad{1'b0}};
        req_valid_pad_s = NPad'(req_valid_i);
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible_s[i] = req_valid_i[i] && (32'(cnt_r[i]) < MAX_OUTSTANDING);
        end
        any_elig_s = 1'b0;
        grant_s    = rr_ptr_r;
        idx_v      = rr_ptr_r;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_elig_s && eligible_s[idx_v]) begin
                any_elig_s = 1'b1;
                grant_s    = idx_v;
            end else begin
                any_elig_s = any_elig_s;
            end
            idx_v = wrap_inc(idx_v);
        end
        if (lock_r) begin
            grant_s    = lock_idx_r;
            cp_valid_o = req_valid_pad_s[lock_idx_r];
        end else begin
            cp_valid_o = any_elig_s;
        end
    end

    // Issue-side muxing of the granted requester onto the coprocessor input.
    always_comb begin
        cp_ctl_o   = req_ctl_i[grant_s];
        cp_tag_o   = grant_s;
        cp_rs1_o   = req_rs1_i[int'(grant_s)*DATA_WIDTH +: DATA_WIDTH];
        cp_rs2_o   = req_rs2_i[int'(grant_s)*DATA_WIDTH +: DATA_WIDTH];
        issue_hs_s = cp_valid_o && cp_ready_i;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = cp_ready_i && cp_valid_o && (grant_s == IdW'(i));
        end
    end

    // Result routing by returned tag; out-of-range tags are accepted and dropped.
    always_comb begin
        rsp_ready_pad_s = NPad'(rsp_ready_i);
        tag_ok_s        = (32'(cp_tag_i) < NUM_REQ);
        rsp_rd_o        = cp_rd_i;
        cp_flush_o      = flush_i;
        if (tag_ok_s) begin
            cp_ready_o = rsp_ready_pad_s[cp_tag_i];
        end else begin
            cp_ready_o = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_o[i] = cp_valid_i && tag_ok_s && (cp_tag_i == IdW'(i));
        end
        rsp_hs_s = cp_valid_i && cp_ready_o;
    end

    // Outstanding-counter next state; simultaneous issue and return cancel out.
    always_comb begin
        err_next_s = rsp_hs_s && !tag_ok_s;
        for (int i = 0; i < NUM_REQ; i++) begin
            inc_s[i]      = issue_hs_s && (grant_s == IdW'(i));
            dec_s[i]      = rsp_hs_s && tag_ok_s && (cp_tag_i == IdW'(i));
            cnt_next_s[i] = cnt_r[i];
            if (inc_s[i] && !dec_s[i]) begin
                cnt_next_s[i] = cnt_r[i] + CntW'(1);
            end else if (dec_s[i] && !inc_s[i]) begin
                if (cnt_r[i] == {CntW{1'b0}}) begin
                    err_next_s = 1'b1;
                end else begin
                    cnt_next_s[i] = cnt_r[i] - CntW'(1);
                end
            end else begin
                cnt_next_s[i] = cnt_r[i];
            end
        end
    end

    // State registers; reset and flush both return everything to idle.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rr_ptr_r   <= {IdW{1'b0}};
            lock_idx_r <= {IdW{1'b0}};
            lock_r     <= 1'b0;
            err_r      <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_r[i] <= {CntW{1'b0}};
            end
        end else begin
            err_r <= err_next_s;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
            if (issue_hs_s) begin
                rr_ptr_r <= wrap_inc(grant_s);
                lock_r   <= 1'b0;
            end else if (cp_valid_o) begin
                lock_r     <= 1'b1;
                lock_idx_r <= grant_s;
            end else begin
                lock_r <= lock_r;
            end
        end
    end

    // Busy flag straight from the counter registers.
    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            busy_o = busy_o | (cnt_r[i] != {CntW{1'b0}});
        end
        err_o = err_r;
    end
endmodule

// File: tb/tb_dummy_arbiter.sv
// Randomised bench for dummy_arbiter: 3 requesters (so tag 3 is an invalid tag)
// and a shallow outstanding limit, compared each cycle with a behavioural model.
module tb_dummy_arbiter;
    import dummy_pkg::*;

    localparam int NR = 3;
    localparam int DW = 32;
    localparam int MO = 2;
    localparam int IW = 2;

    logic                   clk = 1'b0;
    logic                   rst_i, flush_i;
    logic [NR-1:0]          req_valid_i, req_ready_o;
    coproc_ctl_t [NR-1:0]   req_ctl_i;
    logic [NR*DW-1:0]       req_rs1_i, req_rs2_i;
    logic [NR-1:0]          rsp_valid_o, rsp_ready_i;
    logic [DW-1:0]          rsp_rd_o;
    logic                   cp_flush_o, cp_valid_o, cp_ready_i;
    coproc_ctl_t            cp_ctl_o;
    logic [IW-1:0]          cp_tag_o;
    logic [DW-1:0]          cp_rs1_o, cp_rs2_o;
    logic                   cp_valid_i, cp_ready_o;
    logic [IW-1:0]          cp_tag_i;
    logic [DW-1:0]          cp_rd_i;
    logic                   busy_o, err_o;

    always #5 clk = ~clk;

    dummy_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_ctl_i(req_ctl_i),
        .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rd_o(rsp_rd_o),
        .cp_flush_o(cp_flush_o), .cp_valid_o(cp_valid_o), .cp_ready_i(cp_ready_i),
        .cp_ctl_o(cp_ctl_o), .cp_tag_o(cp_tag_o), .cp_rs1_o(cp_rs1_o), .cp_rs2_o(cp_rs2_o),
        .cp_valid_i(cp_valid_i), .cp_ready_o(cp_ready_o), .cp_tag_i(cp_tag_i),
        .cp_rd_i(cp_rd_i), .busy_o(busy_o), .err_o(err_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: counts of in-flight ops, fairness pointer, held grant.
    int m_cnt [NR];
    int m_rr, m_lock, m_lidx, m_err;

    // Requester-side state: an op stays presented until it is accepted.
    bit          pend [NR];
    logic [DW-1:0] d1 [NR];
    logic [DW-1:0] d2 [NR];
    coproc_ctl_t   c  [NR];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        m_rr = 0; m_lock = 0; m_lidx = 0; m_err = 0;
    endtask

    task automatic drive_inputs();
        rst_i   = ($urandom_range(0, 249) == 0);
        flush_i = ($urandom_range(0, 99) == 0);
        for (int i = 0; i < NR; i++) begin
            if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
                pend[i] = 1'b1;
                d1[i]   = $urandom;
                d2[i]   = $urandom;
                c[i]    = coproc_ctl_t'($urandom_range(0, 7));
            end
            req_valid_i[i]            = pend[i];
            req_rs1_i[i*DW +: DW]     = d1[i];
            req_rs2_i[i*DW +: DW]     = d2[i];
            req_ctl_i[i]              = c[i];
            rsp_ready_i[i]            = ($urandom_range(0, 3) != 0);
        end
        cp_ready_i = ($urandom_range(0, 3) != 0);
        cp_valid_i = ($urandom_range(0, 1) == 1);
        cp_tag_i   = ($urandom_range(0, 9) == 0) ? IW'(3) : IW'($urandom_range(0, NR-1));
        cp_rd_i    = $urandom;
    endtask

    // Predict outputs from the reference state, compare, then advance the model.
    task automatic check_and_step();
        int g, v, tag, tag_ok, exp_cprdy, iss, rh, busy;
        logic [NR-1:0] exp_rdy, exp_rv;
        g = m_rr; v = 0;
        if (m_lock != 0) begin
            g = m_lidx;
            v = int'(req_valid_i[g]);
        end else begin
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (m_rr + k) % NR;
                if (v == 0 && req_valid_i[j] && m_cnt[j] < MO) begin
                    v = 1; g = j;
                end
            end
        end
        tag    = int'(cp_tag_i);
        tag_ok = (tag < NR) ? 1 : 0;
        exp_cprdy = tag_ok ? int'(rsp_ready_i[tag]) : 1;
        busy = 0;
        for (int i = 0; i < NR; i++) begin
            exp_rdy[i] = (cp_ready_i && v == 1 && g == i);
            exp_rv[i]  = (cp_valid_i && tag_ok == 1 && tag == i);
            if (m_cnt[i] != 0) busy = 1;
        end

        check_eq("cp_valid", cp_valid_o, v);
        if (v == 1) begin
            check_eq("cp_tag", cp_tag_o, g);
            check_eq("cp_rs1", cp_rs1_o, d1[g]);
            check_eq("cp_rs2", cp_rs2_o, d2[g]);
            check_eq("cp_ctl", cp_ctl_o, c[g]);
        end
        check_eq("req_ready", req_ready_o, exp_rdy);
        check_eq("rsp_valid", rsp_valid_o, exp_rv);
        check_eq("cp_ready_o", cp_ready_o, exp_cprdy);
        check_eq("rsp_rd", rsp_rd_o, cp_rd_i);
        check_eq("cp_flush", cp_flush_o, flush_i);
        check_eq("busy", busy_o, busy);
        check_eq("err", err_o, m_err);

        for (int i = 0; i < NR; i++) if (exp_rdy[i]) pend[i] = 1'b0;

        if (rst_i || flush_i) begin
            model_clear();
        end else begin
            iss = (v == 1 && cp_ready_i) ? 1 : 0;
            rh  = (cp_valid_i && exp_cprdy == 1) ? 1 : 0;
            m_err = (rh == 1 && tag_ok == 0) ? 1 : 0;
            for (int i = 0; i < NR; i++) begin
                bit inc, dec;
                inc = (iss == 1 && g == i);
                dec = (rh == 1 && tag_ok == 1 && tag == i);
                if (inc && !dec) m_cnt[i]++;
                else if (dec && !inc) begin
                    if (m_cnt[i] == 0) m_err = 1;
                    else m_cnt[i]--;
                end
            end
            if (iss == 1) begin
                m_rr = (g + 1) % NR; m_lock = 0;
            end else if (v == 1) begin
                m_lock = 1; m_lidx = g;
            end
        end
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; req_valid_i = '0; req_ctl_i = '0;
        req_rs1_i = '0; req_rs2_i = '0; rsp_ready_i = '0; cp_ready_i = 1'b0;
        cp_valid_i = 1'b0; cp_tag_i = '0; cp_rd_i = '0;
        for (int i = 0; i < NR; i++) begin
            pend[i] = 1'b0; d1[i] = '0; d2[i] = '0; c[i] = coproc_ctl_t'(3'd0);
        end
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check_eq("reset_cp_valid", cp_valid_o, 1'b0);
        check_eq("reset_busy", busy_o, 1'b0);
        check_eq("reset_err", err_o, 1'b0);
        check_eq("reset_ready", req_ready_o, 3'b000);
        @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            drive_inputs();
            @(negedge clk);
            check_and_step();
            @(posedge clk);
            #1;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
